// File: rtl/csr_access_unit.sv
// Zicsr instruction sequencer: reads a CSR, issues at most one write, and
// returns the old value with an illegal-instruction flag.
module csr_access_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_funct3,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_rs1_val,
   input  logic [4:0]      req_zimm,
   input  logic            req_rd_nonzero,
   input  logic [1:0]      cur_priv,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_illegal,
   output logic            resp_rd_we,
   output logic [11:0]     csr_addr,
   output logic            csr_we,
   output logic [XLEN-1:0] csr_wdata,
   input  logic [XLEN-1:0] csr_rdata
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t            state;
   state_t            state_next;
   logic [2:0]        funct3;
   logic [11:0]       addr;
   logic [4:0]        zimm;
   logic [XLEN-1:0]   rs1_val;
   logic              rd_nonzero;
   logic [1:0]        priv;
   logic [XLEN-1:0]   old;
   logic [XLEN-1:0]   rdata;
   logic              illegal;
   logic              rd_we;
   logic [XLEN-1:0]   src;
   logic              write_intent;
   logic              illegal_now;

   // Operand selection, write intent and legality from the captured instruction
   always_comb begin
      src          = {XLEN{1'b0}};
      write_intent = 1'b0;
      illegal_now  = 1'b0;
      if (funct3[2]) begin
         src = {{(XLEN-5){1'b0}}, zimm};
      end else begin
         src = rs1_val;
      end
      // Set/clear forms only write when the rs1 field itself is nonzero
      if (funct3[1:0] == 2'b01) begin
         write_intent = 1'b1;
      end else begin
         write_intent = (zimm != 5'd0);
      end
      illegal_now = (funct3[1:0] == 2'b00) ||
                    (addr[9:8] > priv) ||
                    (write_intent && (addr[11:10] == 2'b11));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = req_valid ? READ : IDLE;
         READ:    state_next = (illegal_now || !write_intent) ? RESP : WRITE;
         WRITE:   state_next = RESP;
         RESP:    state_next = resp_ready ? IDLE : RESP;
         default: state_next = IDLE;
      endcase
   end

   // Instruction capture on accept, read-data and response capture in READ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         funct3     <= 3'd0;
         addr       <= 12'd0;
         zimm       <= 5'd0;
         rs1_val    <= {XLEN{1'b0}};
         rd_nonzero <= 1'b0;
         priv       <= 2'd0;
         old        <= {XLEN{1'b0}};
         rdata      <= {XLEN{1'b0}};
         illegal    <= 1'b0;
         rd_we      <= 1'b0;
      end else begin
         if ((state == IDLE) && req_valid) begin
            funct3     <= req_funct3;
            addr       <= req_addr;
            zimm       <= req_zimm;
            rs1_val    <= req_rs1_val;
            rd_nonzero <= req_rd_nonzero;
            priv       <= cur_priv;
         end
         if (state == READ) begin
            old     <= csr_rdata;
            illegal <= illegal_now;
            rdata   <= illegal_now ? {XLEN{1'b0}} : csr_rdata;
            rd_we   <= rd_nonzero & ~illegal_now;
         end
      end
   end

   // Write data: only driven in WRITE, so the bus is quiet otherwise
   always_comb begin
      csr_wdata = {XLEN{1'b0}};
      if (state == WRITE) begin
         case (funct3[1:0])
            2'b01:   csr_wdata = src;
            2'b10:   csr_wdata = old | src;
            2'b11:   csr_wdata = old & ~src;
            default: csr_wdata = {XLEN{1'b0}};
         endcase
      end else begin
         csr_wdata = {XLEN{1'b0}};
      end
   end

   assign req_ready    = (state == IDLE);
   assign resp_valid   = (state == RESP);
   assign csr_we       = (state == WRITE);
   assign csr_addr     = addr;
   assign resp_rdata   = rdata;
   assign resp_illegal = illegal;
   assign resp_rd_we   = rd_we;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed plan cases plus random instructions
// checked against a rule-level reference model and a model CSR file.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = 3'd0;
   logic [11:0] req_addr = 12'd0;
   logic [63:0] req_rs1_val = 64'd0;
   logic [4:0]  req_zimm = 5'd0;
   logic        req_rd_nonzero = 1'b0;
   logic [1:0]  cur_priv = 2'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_rdata;
   logic        resp_illegal;
   logic        resp_rd_we;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [63:0] csr_wdata;
   logic [63:0] csr_rdata;

   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = 12'd0;
   logic [63:0] pre_data = 64'd0;
   logic [63:0] csr_mem [0:4095];
   logic [63:0] ref_mem [0:4095];

   int checks = 0;
   int errors = 0;

   logic [11:0] addr_tab [0:7] = '{12'h040, 12'h041, 12'h140, 12'h340,
                                   12'h300, 12'hC00, 12'hC01, 12'h240};
   logic [1:0]  priv_tab [0:2] = '{2'd0, 2'd1, 2'd3};

   always #5 clk = ~clk;

   csr_access_unit #(.XLEN(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_addr(req_addr),
      .req_rs1_val(req_rs1_val), .req_zimm(req_zimm),
      .req_rd_nonzero(req_rd_nonzero), .cur_priv(cur_priv),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
      .resp_rd_we(resp_rd_we), .csr_addr(csr_addr), .csr_we(csr_we),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
   );

   // Model CSR file: combinational read, synchronous write
   assign csr_rdata = csr_mem[csr_addr];
   always @(posedge clk) begin
      if (pre_we) csr_mem[pre_addr] <= pre_data;
      else if (csr_we) csr_mem[csr_addr] <= csr_wdata;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [63:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_txn(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                          input logic [4:0] zi, input logic rdnz, input logic [1:0] pv,
                          input int hold);
      logic [63:0] src, old_v, new_v, exp_rdata;
      logic        legal_f3, wi, ill, do_wr;
      int          exp_lat, lat, we_cnt, we_cyc;
      logic [63:0] wd;
      // Reference: instruction semantics straight from the Zicsr rules
      legal_f3 = (f3 != 3'd0) && (f3 != 3'd4);
      src      = f3[2] ? {59'd0, zi} : rs1;
      wi       = (f3[1:0] == 2'b01) || (zi != 5'd0);
      ill      = !legal_f3 || (a[9:8] > pv) || (wi && a[11:10] == 2'b11);
      do_wr    = !ill && wi;
      old_v    = ref_mem[a];
      case (f3[1:0])
         2'b01:   new_v = src;
         2'b10:   new_v = old_v | src;
         2'b11:   new_v = old_v & ~src;
         default: new_v = old_v;
      endcase
      exp_rdata = ill ? 64'd0 : old_v;
      exp_lat   = do_wr ? 3 : 2;

      @(negedge clk);
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_val = rs1;
      req_zimm = zi; req_rd_nonzero = rdnz; cur_priv = pv;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0; we_cnt = 0; we_cyc = 0; wd = 64'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) check("csr_addr_read", {52'd0, csr_addr}, {52'd0, a});
         if (csr_we) begin
            we_cnt++; we_cyc = k; wd = csr_wdata;
         end
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      check("resp_latency", 64'(lat), 64'(exp_lat));
      check("csr_we_count", 64'(we_cnt), do_wr ? 64'd1 : 64'd0);
      if (do_wr) begin
         check("csr_we_cycle", 64'(we_cyc), 64'd2);
         check("csr_wdata", wd, new_v);
      end
      check("resp_rdata", resp_rdata, exp_rdata);
      check("resp_illegal", {63'd0, resp_illegal}, {63'd0, ill});
      check("resp_rd_we", {63'd0, resp_rd_we}, {63'd0, rdnz & ~ill});
      check("req_ready_busy", {63'd0, req_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; req_funct3 = 3'd1; req_addr = 12'h041;
         @(negedge clk);
         check("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
         check("hold_resp_rdata", resp_rdata, exp_rdata);
         check("hold_resp_illegal", {63'd0, resp_illegal}, {63'd0, ill});
         check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_done", {63'd0, resp_valid}, 64'd0);
      if (do_wr) ref_mem[a] = new_v;
      check("csr_contents", csr_mem[a], ref_mem[a]);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         csr_mem[addr_tab[i]] = 64'd0;
         ref_mem[addr_tab[i]] = 64'd0;
      end
      repeat (2) @(negedge clk);
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_csr_we", {63'd0, csr_we}, 64'd0);
      check("rst_csr_addr", {52'd0, csr_addr}, 64'd0);
      rst = 1'b0;

      preload(12'h040, 64'h1234);
      run_txn(3'b001, 12'h040, 64'hDEADBEEF, 5'd1, 1'b1, 2'd3, 0);
      check("rw_result", csr_mem[12'h040], 64'hDEADBEEF);
      run_txn(3'b010, 12'h040, 64'hFF, 5'd0, 1'b1, 2'd3, 0);

      preload(12'h040, 64'hFF);
      run_txn(3'b011, 12'h040, 64'h0F, 5'd1, 1'b1, 2'd3, 0);
      check("rc_result", csr_mem[12'h040], 64'hF0);
      run_txn(3'b110, 12'h040, 64'h0, 5'd5, 1'b1, 2'd3, 0);
      check("rsi_result", csr_mem[12'h040], 64'hF5);
      run_txn(3'b101, 12'h040, 64'h0, 5'd3, 1'b1, 2'd3, 0);
      check("rwi_result", csr_mem[12'h040], 64'h3);

      run_txn(3'b100, 12'h040, 64'h55, 5'd2, 1'b1, 2'd3, 0);
      preload(12'hC00, 64'h77);
      run_txn(3'b001, 12'hC00, 64'h99, 5'd1, 1'b1, 2'd3, 0);
      run_txn(3'b010, 12'hC00, 64'h99, 5'd0, 1'b1, 2'd3, 0);
      run_txn(3'b010, 12'h300, 64'h1, 5'd0, 1'b1, 2'd0, 0);

      run_txn(3'b001, 12'h041, 64'hCAFE, 5'd4, 1'b1, 2'd3, 3);

      // Reset during the WRITE cycle must abort the write
      preload(12'h140, 64'hAAAA);
      @(negedge clk);
      req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h140;
      req_rs1_val = 64'h5555; req_zimm = 5'd1; cur_priv = 2'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_csr_we", {63'd0, csr_we}, 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_csr_we", {63'd0, csr_we}, 64'd0);
      check("mid_rst_csr_wdata", csr_wdata, 64'd0);
      check("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("mid_rst_resp_rdata", resp_rdata, 64'd0);
      check("mid_rst_csr_addr", {52'd0, csr_addr}, 64'd0);
      @(posedge clk); #1;
      check("rst_no_commit", csr_mem[12'h140], 64'hAAAA);
      @(negedge clk);
      rst = 1'b0;
      run_txn(3'b011, 12'h140, 64'h00FF, 5'd9, 1'b0, 2'd1, 1);

      for (int n = 0; n < 40; n++) begin
         logic [4:0] zi;
         zi = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         run_txn(3'($urandom_range(0, 7)), addr_tab[$urandom_range(0, 7)],
                 {$urandom, $urandom}, zi, 1'($urandom_range(0, 1)),
                 priv_tab[$urandom_range(0, 2)], $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer that executes RISC-V Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms) against a CSR register file such as the user-level CSR bank. Sits between the execute stage and the CSR file: it accepts one decoded CSR instruction, performs the read, computes and issues at most one write, and returns the old CSR value plus an illegal-instruction flag. It is the initiator side of the CSR file's combinational-read / synchronous-write port.

## Interface

Parameters:
- XLEN, 64, data width of CSRs and rs1 operand

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CSR instruction offered
- req_ready  out  1  unit idle, can accept
- req_funct3  in  3  instruction funct3
- req_addr  in  12  CSR address
- req_rs1_val  in  XLEN  rs1 register value
- req_zimm  in  5  rs1 field / immediate
- req_rd_nonzero  in  1  rd != x0, passed through to the response
- cur_priv  in  2  current privilege level (0=U, 1=S, 3=M)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_rdata  out  XLEN  old CSR value (0 if illegal)
- resp_illegal  out  1  illegal-instruction exception
- resp_rd_we  out  1  req_rd_nonzero & ~resp_illegal
- csr_addr  out  12  address to CSR file
- csr_we  out  1  write strobe to CSR file
- csr_wdata  out  XLEN  write data to CSR file
- csr_rdata  in  XLEN  combinational read data from CSR file

## Operation

- FSM states: IDLE, READ, WRITE, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, capture funct3, addr, zimm, rs1_val, rd_nonzero, cur_priv; go to READ.
- Decode funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000 and 100 are illegal.
- src = rs1_val for 001/010/011; zero-extended zimm for 101/110/111.
- Write intent: RW/RWI always; RS/RC/RSI/RCI only if zimm != 0 (the rs1 field, not the rs1 value).
- READ: csr_addr = captured addr; register csr_rdata into old. illegal = bad funct3 OR addr[9:8] > cur_priv OR (write intent AND addr[11:10]==2'b11). Next: illegal or no write intent -> RESP; else WRITE.
- WRITE: csr_we=1 for exactly this one cycle. csr_wdata: RW = src; RS = old | src; RC = old & ~src. Next: RESP.
- RESP: resp_valid=1; resp_rdata = illegal ? 0 : old; resp_illegal, resp_rd_we stable. Advance to IDLE on resp_ready; hold all outputs otherwise.
- csr_addr is the captured addr in every state; csr_we is 0 outside WRITE; csr_wdata is 0 outside WRITE.
- Only one instruction in flight; req_ready=0 in READ, WRITE, RESP.

## Timing

- Handshake at edge N. READ during cycle N+1.
- With write: WRITE in cycle N+2 (CSR updates at edge N+3); resp_valid from cycle N+3.
- Without write or illegal: resp_valid from cycle N+2.
- Earliest next accept: the edge after resp handshake (IDLE cycle in between; no same-cycle resp/req overlap).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, resp_rd_we=0, csr_we=0, csr_wdata=0, csr_addr=0; all captured registers 0.
- Reset asserted mid-operation (any state, incl. WRITE): async return to IDLE, csr_we drops immediately, no write commits at the following edge, pending response discarded.
- csr_we is decoded from registered state only (glitch-free, no combinational path from req_* to csr_we).

## Test plan

- CSR file preset 0x040 = 0x1234; CSRRW addr 0x040, rs1_val 0xDEADBEEF -> csr_we one cycle at N+2 with wdata 0xDEADBEEF, resp_rdata 0x1234 at N+3, CSR reads 0xDEADBEEF afterwards.
- CSRRS addr 0x040, zimm field 0, rs1_val 0xFF -> no csr_we, resp_valid at N+2, resp_rdata = current value.
- CSR = 0xFF; CSRRC rs1_val 0x0F -> wdata 0xF0; then CSRRSI zimm 5 -> wdata 0xF5; CSRRWI zimm 3 -> wdata 0x3.
- Illegal: funct3 100 -> resp_illegal=1, rdata 0, resp_rd_we 0, no csr_we; CSRRW to 0xC00 -> illegal; CSRRS zimm 0 to 0xC00 -> legal; access 0x300 at cur_priv=0 -> illegal.
- Backpressure: resp_ready low 3 cycles -> resp_valid/rdata stable, req_ready 0, second req_valid not accepted until after resp handshake.
- Assert rst during WRITE cycle -> csr_we falls immediately, target CSR unchanged, outputs at reset values, next request processes normally.
